// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// rst_seq_ctrl : reset synchronizer plus staged per-domain reset release, with
//                software reset request/acknowledge handshake.
// Optional feature macro: RST_SEQ_TIMEOUT_EN (sticky request-drop timeout flag).
// Revision: 1.0
// ============================================================================

module rst_seq_ctrl #(
  parameter int N_STAGES    = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int WDT_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_rst_req_i,
  output logic                sw_rst_ack_o,
  output logic [N_STAGES-1:0] rst_stage_o,
  output logic                seq_done_o,
  output logic [1:0]          state_o
`ifdef RST_SEQ_TIMEOUT_EN
  ,
  output logic                sw_rst_timeout_o
`endif
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] C_GAP_LAST  = 8'(STAGE_GAP - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  rst_sync_w;

  state_t                state_q, state_d;
  logic [N_STAGES-1:0]   stage_q, stage_d, stage_shift_w;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  sw_seq_q, sw_seq_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  release_w;

  // Asynchronous assert, synchronous deassert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
    end
  end

  assign rst_sync_w = sync_q[SYNC_DEPTH-1];

  // Stages release as a thermometer from bit 0 upward.
  assign stage_shift_w = stage_q << 1;

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    done_d     = done_q;
    ack_d      = ack_q;
    sw_seq_d   = sw_seq_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    release_w  = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        // The synchronizer output settles one edge late, so the first
        // hold cycle is already consumed when leaving SYNC.
        if (!rst_sync_w) begin
          if (HOLD_CYCLES == 1) begin
            release_w = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == C_HOLD_LAST) begin
          release_w = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (gap_cnt_q == C_GAP_LAST) begin
          release_w = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (ack_q) begin
          if (!sw_rst_req_i) begin
            ack_d = 1'b0;
          end
        end else if (sw_rst_req_i) begin
          state_d    = ST_HOLD;
          stage_d    = '1;
          done_d     = 1'b0;
          sw_seq_d   = 1'b1;
          hold_cnt_d = 8'd0;
          gap_cnt_d  = 8'd0;
        end
      end
    endcase

    if (release_w) begin
      stage_d    = stage_shift_w;
      hold_cnt_d = 8'd0;
      gap_cnt_d  = 8'd0;
      if (stage_shift_w == '0) begin
        state_d  = ST_RUN;
        done_d   = 1'b1;
        ack_d    = sw_seq_q;
        sw_seq_d = 1'b0;
      end else begin
        state_d  = ST_RELEASE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      stage_q    <= '1;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      sw_seq_q   <= 1'b0;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      sw_seq_q   <= sw_seq_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign rst_stage_o  = stage_q;
  assign seq_done_o   = done_q;
  assign sw_rst_ack_o = ack_q;
  assign state_o      = state_q;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int C_WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [C_WDT_W-1:0] C_WDT_LAST = C_WDT_W'(WDT_CYCLES - 1);

  logic [C_WDT_W-1:0] wdt_cnt_q;
  logic               timeout_q;

  // Counts consecutive cycles of a request still held after acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (ack_q && sw_rst_req_i) begin
      if (wdt_cnt_q == C_WDT_LAST) begin
        timeout_q <= 1'b1;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + C_WDT_W'(1);
      end
    end else begin
      wdt_cnt_q <= '0;
    end
  end

  assign sw_rst_timeout_o = timeout_q;
`else
  logic unused_wdt_w;
  assign unused_wdt_w = (WDT_CYCLES > 0);
`endif

endmodule

`default_nettype wire

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter N_STAGES, default 4: number of sequenced reset domains (legal 1..8).
REQ-002 Parameter SYNC_DEPTH, default 2: reset-synchronizer flop count (legal 2..4).
REQ-003 Parameter HOLD_CYCLES, default 4: cycles all stages stay in reset after the synchronized release (legal 1..255).
REQ-004 Parameter STAGE_GAP, default 2: cycles between consecutive stage releases (legal 1..255).
REQ-005 Parameter WDT_CYCLES, default 16: request-drop timeout, used only when RST_SEQ_TIMEOUT_EN is defined.
REQ-006 clk  in  1  single clock; all state is updated on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 sw_rst_req_i  in  1  software reset request, 4-phase level handshake.
REQ-009 sw_rst_ack_o  out  1  software reset acknowledge.
REQ-010 rst_stage_o  out  N_STAGES  active-high reset per domain; bit k is released after bit k-1.
REQ-011 seq_done_o  out  1  high while all stages are released (state RUN).
REQ-012 state_o  out  2  FSM state encoding: SYNC=0, HOLD=1, RELEASE=2, RUN=3.
REQ-013 sw_rst_timeout_o  out  1  sticky timeout flag; present only when RST_SEQ_TIMEOUT_EN is defined.

Function
REQ-014 The reset input shall be synchronized through SYNC_DEPTH flops with asynchronous assert and synchronous deassert.
REQ-015 The block shall use states SYNC -> HOLD -> RELEASE -> RUN, plus a RUN -> HOLD transition on an accepted software request.
- SYNC: exit when the synchronized reset is low.
- HOLD: count HOLD_CYCLES.
- RELEASE: release one stage every STAGE_GAP cycles, starting from bit 0.
REQ-016 Edge numbering: the first rising edge with reset low is edge 1. Bit k of rst_stage_o shall go to 0 immediately after edge SYNC_DEPTH+HOLD_CYCLES+k*STAGE_GAP.
REQ-017 seq_done_o shall rise, and the FSM shall enter RUN, on the same edge as the highest stage release.
REQ-018 Once released, a stage bit shall stay 0 until the next reset or accepted software request.
REQ-019 A software request is accepted only at an edge n where all three hold: state is RUN, sw_rst_req_i=1, sw_rst_ack_o=0.
REQ-020 Requests in any other state or condition are not accepted. A request held high from boot is accepted at the first edge in RUN.
REQ-021 After accepting edge n:
- all rst_stage_o bits shall be 1 and seq_done_o shall be 0;
- bit k shall release after edge n+HOLD_CYCLES+k*STAGE_GAP;
- the SYNC state is skipped.
REQ-022 sw_rst_ack_o shall rise on the edge of the final stage release of a software sequence.
REQ-023 sw_rst_ack_o shall stay high until sw_rst_req_i is sampled low, then fall after that edge.
REQ-024 While sw_rst_ack_o is high, a high sw_rst_req_i shall have no effect.
REQ-025 If sw_rst_req_i drops before the sequence completes, the sequence shall still complete. ack shall then pulse high for exactly one cycle.
REQ-026 Counters shall be sized for the maximum legal parameter values and shall not wrap during a sequence.

Reset
REQ-027 While reset=1, with no clock required:
- rst_stage_o shall be all ones;
- state_o=SYNC;
- seq_done_o=0, sw_rst_ack_o=0;
- all counters shall be 0.
REQ-028 Reset asserted mid-sequence or simultaneously with a request shall win: the whole boot sequence per REQ-016 restarts.
REQ-029 sw_rst_timeout_o shall be 0 at reset and cleared only by reset.

Configuration
REQ-030 With RST_SEQ_TIMEOUT_EN defined:
- a counter shall run while sw_rst_ack_o=1 and sw_rst_req_i=1;
- sw_rst_timeout_o shall set after WDT_CYCLES consecutive such cycles.
REQ-031 The timeout flag shall be status only; the handshake shall be unaffected.
REQ-032 Without RST_SEQ_TIMEOUT_EN, the port and counter shall be absent and all other behaviour identical.

Verification (defaults: N_STAGES=4, SYNC_DEPTH=2, HOLD_CYCLES=4, STAGE_GAP=2)
REQ-033 Boot: reset high then low before edge 1 -> rst_stage_o 1111, 1110 after edge 6, 1100 after edge 8, 1000 after edge 10, 0000 plus seq_done_o=1 and state_o=3 after edge 12.
REQ-034 Software reset: req=1 sampled in RUN at edge n:
- after edge n: rst_stage_o=1111, done=0;
- after edge n+10: 0000, ack=1;
- req=0 at edge n+13 -> ack=0 after edge n+13.
REQ-035 Mid-sequence reset: assert reset between edges 9 and 10 -> rst_stage_o=1111 immediately (no clock); after release, the REQ-033 timing repeats exactly.
REQ-036 Early drop: req high for one edge then low -> full software sequence completes and ack is high for exactly one cycle after edge n+10.
REQ-037 Timeout: with RST_SEQ_TIMEOUT_EN and WDT_CYCLES=16, hold req high 16 cycles after ack -> sw_rst_timeout_o=1 and stays 1 after req drops; only reset clears it.
